objects_layer_mux: RTL



---
 rtl/objects_layer_mux.sv | 130 +++++++++++++
 1 files changed

// File: rtl/objects_layer_mux.sv
// objects_layer_mux: final pixel compositor for the VGA object bitmaps.
// Picks the highest-priority layer that requests drawing and registers it
// toward the VGA controller. It also gathers player/wall, player/enemy and
// bomb/brick overlaps over a frame and reports them as one-cycle pulses at
// the next frame start, with a saturating count of frames that collided.
// Optional feature: define COLLISION_TINT_EN to paint overlapping pixels
// (player on wall or player on enemy) with COLL_TINT_RGB.
module objects_layer_mux #(
    parameter logic [7:0] BACKGROUND_RGB = 8'h00,
    parameter logic [7:0] COLL_TINT_RGB  = 8'hE0,
    parameter int         CNT_W          = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             playerDR,
    input  logic [7:0]       playerRGB,
    input  logic             bombDR,
    input  logic [7:0]       bombRGB,
    input  logic             enemyDR,
    input  logic [7:0]       enemyRGB,
    input  logic             columnsDR,
    input  logic [7:0]       columnsRGB,
    input  logic             bricksDR,
    input  logic [7:0]       bricksRGB,
    output logic [7:0]       RGBOut,
    output logic             collPlayerWall,
    output logic             collPlayerEnemy,
    output logic             collBombBrick,
    output logic [CNT_W-1:0] collFrameCount
);

`ifdef COLLISION_TINT_EN
    localparam bit TINT_EN = 1'b1;
`else
    localparam bit TINT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       wall_hit;
    logic       enemy_hit;
    logic       brick_hit;
    logic [7:0] prio_rgb;
    logic [7:0] next_rgb;
    logic       sticky_wall;
    logic       sticky_enemy;
    logic       sticky_brick;
    logic       any_pulse;

    assign wall_hit  = playerDR & (columnsDR | bricksDR);
    assign enemy_hit = playerDR & enemyDR;
    assign brick_hit = bombDR & bricksDR;

    // A pulse fires at a frame boundary whenever anything stuck during the frame
    assign any_pulse = sticky_wall | sticky_enemy | sticky_brick;

    // Fixed layer priority: player, bomb, enemy, columns, bricks, background
    always_comb begin
        prio_rgb = BACKGROUND_RGB;
        if (playerDR)
            prio_rgb = playerRGB;
        else if (bombDR)
            prio_rgb = bombRGB;
        else if (enemyDR)
            prio_rgb = enemyRGB;
        else if (columnsDR)
            prio_rgb = columnsRGB;
        else if (bricksDR)
            prio_rgb = bricksRGB;
    end

    // Tint overrides the priority result only when the feature is compiled in
    always_comb begin
        next_rgb = prio_rgb;
        if (TINT_EN && (wall_hit || enemy_hit))
            next_rgb = COLL_TINT_RGB;
    end

    // Output pixel register, updated every clock
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            RGBOut <= 8'h00;
        else
            RGBOut <= next_rgb;
    end

    // Sticky overlap flags; a hit on the boundary cycle starts the new frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sticky_wall  <= 1'b0;
            sticky_enemy <= 1'b0;
            sticky_brick <= 1'b0;
        end else if (startOfFrame) begin
            sticky_wall  <= wall_hit;
            sticky_enemy <= enemy_hit;
            sticky_brick <= brick_hit;
        end else begin
            sticky_wall  <= sticky_wall  | wall_hit;
            sticky_enemy <= sticky_enemy | enemy_hit;
            sticky_brick <= sticky_brick | brick_hit;
        end
    end

    // Publish last frame's flags as single-cycle pulses after startOfFrame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collPlayerWall  <= 1'b0;
            collPlayerEnemy <= 1'b0;
            collBombBrick   <= 1'b0;
        end else if (startOfFrame) begin
            collPlayerWall  <= sticky_wall;
            collPlayerEnemy <= sticky_enemy;
            collBombBrick   <= sticky_brick;
        end else begin
            collPlayerWall  <= 1'b0;
            collPlayerEnemy <= 1'b0;
            collBombBrick   <= 1'b0;
        end
    end

    // Saturating count of frames that produced at least one collision pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            collFrameCount <= '0;
        else if (startOfFrame && any_pulse && (collFrameCount != CNT_MAX))
            collFrameCount <= collFrameCount + 1'b1;
    end

endmodule
